// File: rtl/axi_channel_slice_if.sv
// -----------------------------------------------------------------------------
// axi_channel_slice_if
//   One AXI valid/ready channel: a handshake pair plus a packed payload.
//   W sets the payload width. The owner of valid and bits uses the master
//   modport. The receiver, which drives ready, uses the slave modport.
//
//   valid  master -> slave  payload present
//   ready  slave  -> master receiver can accept this cycle
//   bits   master -> slave  packed payload, MSB->LSB field order
// -----------------------------------------------------------------------------
interface axi_channel_slice_if #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] bits;

    modport master (output valid, output bits, input ready);
    modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/axi_channel_slice.sv
// -----------------------------------------------------------------------------
// axi_channel_slice
//   AXI4 register slice between the core master port and the MAXI pins.
//   Each of AW, W, B, AR and R has its own mode:
//     0 = bypass, 1 = forward register, 2 = two-entry skid buffer.
//   Outstanding read and write bursts are counted and capped at the address
//   channels. idle reports when every slice is empty and both counters are
//   zero.
//
//   clock           sole clock
//   reset           synchronous, active-high
//   in_aw / in_w    from core   (slave modport)
//   out_aw / out_w  to memory   (master modport)
//   in_b / in_r     from memory (slave modport)
//   out_b / out_r   to core     (master modport)
//   in_ar           from core   (slave modport)
//   out_ar          to memory   (master modport)
//   rd_outstanding  read bursts accepted and not yet finished by an R last beat
//   wr_outstanding  write bursts accepted and not yet answered by a B beat
//   idle            registered; all slices empty and both counters zero
// -----------------------------------------------------------------------------

// One channel stage. Shared by all five channels; MODE selects the structure.
module axi_channel_slice_stage #(
    parameter int W    = 8,
    parameter int MODE = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits,
    output logic         empty
);
    // Every mode gates both handshake sides with reset. Nothing can transfer
    // in a reset cycle, even if a stage still held data before that edge.
    if (MODE == 0) begin : g_bypass
        logic unused_clk;
        assign unused_clk = clock;
        assign out_valid  = in_valid && !reset;
        assign out_bits   = in_bits;
        assign in_ready   = out_ready && !reset;
        assign empty      = 1'b1;
    end else if (MODE == 1) begin : g_forward
        logic         full_q;
        logic [W-1:0] data_q;
        logic         push;
        logic         pop;

        assign out_valid = full_q && !reset;
        assign out_bits  = data_q;
        // The ready path is combinational, so a full stage can still stream.
        assign in_ready  = !reset && (!full_q || out_ready);
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        assign empty     = !full_q;

        // NOTE: state flops use non-blocking assignments so that every flop
        // samples pre-edge values, independent of block evaluation order.
        always_ff @(posedge clock) begin
            if (reset) begin
                full_q <= 1'b0;
            end else if (push) begin
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
        end

        // NOTE: payload storage is deliberately left unreset. The valid flag
        // alone decides whether the data is meaningful, which keeps reset off
        // the wide datapath.
        always_ff @(posedge clock) begin
            if (push) begin
                data_q <= in_bits;
            end
        end
    end else begin : g_skid
        logic [W-1:0] mem [2];
        logic         head;
        logic [1:0]   count;
        logic [1:0]   count_nxt;
        logic         rdy_q;
        logic         vld_q;
        logic         push;
        logic         pop;
        logic         wr_idx;

        assign in_ready  = rdy_q && !reset;
        assign out_valid = vld_q && !reset;
        assign out_bits  = mem[head];
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        assign empty     = (count == 2'd0);
        // The tail sits one past the head when one entry is held. With a
        // simultaneous pop the head moves onto that slot, which keeps order.
        assign wr_idx    = head ^ count[0];

        // NOTE: the default assignment comes first, so every path assigns
        // count_nxt and no latch is inferred.
        always_comb begin
            count_nxt = count;
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end

        // ready and valid are recomputed from the next count and registered.
        // No combinational path from the input side reaches the output side.
        always_ff @(posedge clock) begin
            if (reset) begin
                head  <= 1'b0;
                count <= 2'd0;
                rdy_q <= 1'b1;
                vld_q <= 1'b0;
            end else begin
                count <= count_nxt;
                rdy_q <= (count_nxt < 2'd2);
                vld_q <= (count_nxt != 2'd0);
                if (pop) begin
                    head <= ~head;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_idx] <= in_bits;
            end
        end
    end
endmodule

module axi_channel_slice #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MODE_AW = 2,
    parameter int MODE_W  = 2,
    parameter int MODE_B  = 2,
    parameter int MODE_AR = 2,
    parameter int MODE_R  = 2,
    parameter int MAX_RD  = 4,
    parameter int MAX_WR  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    axi_channel_slice_if.slave    in_aw,
    axi_channel_slice_if.master   out_aw,
    axi_channel_slice_if.slave    in_w,
    axi_channel_slice_if.master   out_w,
    axi_channel_slice_if.slave    in_b,
    axi_channel_slice_if.master   out_b,
    axi_channel_slice_if.slave    in_ar,
    axi_channel_slice_if.master   out_ar,
    axi_channel_slice_if.slave    in_r,
    axi_channel_slice_if.master   out_r,
    output logic [3:0]            rd_outstanding,
    output logic [3:0]            wr_outstanding,
    output logic                  idle
);
    localparam int AX_W = ID_W + ADDR_W + 13;
    localparam int W_W  = DATA_W + DATA_W / 8 + 1;
    localparam int B_W  = ID_W + 2;
    localparam int R_W  = ID_W + DATA_W + 3;

    localparam logic [3:0] RD_CAP = 4'(MAX_RD);
    localparam logic [3:0] WR_CAP = 4'(MAX_WR);

    logic rd_full, wr_full;
    logic ar_in_valid, ar_in_ready, aw_in_valid, aw_in_ready;
    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic rd_inc, rd_dec, wr_inc, wr_dec;

    // At the cap, the request is hidden from the slice and ready is forced
    // low toward the core. Both sides therefore see the same decision.
    assign rd_full     = (rd_outstanding == RD_CAP);
    assign wr_full     = (wr_outstanding == WR_CAP);
    assign ar_in_valid = in_ar.valid && !rd_full;
    assign aw_in_valid = in_aw.valid && !wr_full;
    assign in_ar.ready = ar_in_ready && !rd_full;
    assign in_aw.ready = aw_in_ready && !wr_full;

    assign rd_inc = ar_in_valid && ar_in_ready;
    assign rd_dec = out_r.valid && out_r.ready && out_r.bits[0];
    assign wr_inc = aw_in_valid && aw_in_ready;
    assign wr_dec = out_b.valid && out_b.ready;

    axi_channel_slice_stage #(.W(AX_W), .MODE(MODE_AW)) u_aw (
        .clock(clock), .reset(reset),
        .in_valid(aw_in_valid), .in_ready(aw_in_ready), .in_bits(in_aw.bits),
        .out_valid(out_aw.valid), .out_ready(out_aw.ready), .out_bits(out_aw.bits),
        .empty(aw_empty)
    );

    axi_channel_slice_stage #(.W(W_W), .MODE(MODE_W)) u_w (
        .clock(clock), .reset(reset),
        .in_valid(in_w.valid), .in_ready(in_w.ready), .in_bits(in_w.bits),
        .out_valid(out_w.valid), .out_ready(out_w.ready), .out_bits(out_w.bits),
        .empty(w_empty)
    );

    axi_channel_slice_stage #(.W(B_W), .MODE(MODE_B)) u_b (
        .clock(clock), .reset(reset),
        .in_valid(in_b.valid), .in_ready(in_b.ready), .in_bits(in_b.bits),
        .out_valid(out_b.valid), .out_ready(out_b.ready), .out_bits(out_b.bits),
        .empty(b_empty)
    );

    axi_channel_slice_stage #(.W(AX_W), .MODE(MODE_AR)) u_ar (
        .clock(clock), .reset(reset),
        .in_valid(ar_in_valid), .in_ready(ar_in_ready), .in_bits(in_ar.bits),
        .out_valid(out_ar.valid), .out_ready(out_ar.ready), .out_bits(out_ar.bits),
        .empty(ar_empty)
    );

    axi_channel_slice_stage #(.W(R_W), .MODE(MODE_R)) u_r (
        .clock(clock), .reset(reset),
        .in_valid(in_r.valid), .in_ready(in_r.ready), .in_bits(in_r.bits),
        .out_valid(out_r.valid), .out_ready(out_r.ready), .out_bits(out_r.bits),
        .empty(r_empty)
    );

    // A simultaneous increment and decrement cancel. A stray decrement at
    // zero saturates instead of wrapping.
    function automatic logic [3:0] next_count(input logic [3:0] cur,
                                              input logic inc, input logic dec);
        if (inc && !dec) begin
            return cur + 4'd1;
        end
        if (dec && !inc && cur != 4'd0) begin
            return cur - 4'd1;
        end
        return cur;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_outstanding <= 4'd0;
            wr_outstanding <= 4'd0;
            idle           <= 1'b1;
        end else begin
            rd_outstanding <= next_count(rd_outstanding, rd_inc, rd_dec);
            wr_outstanding <= next_count(wr_outstanding, wr_inc, wr_dec);
            idle           <= aw_empty && w_empty && b_empty && ar_empty && r_empty
                              && rd_outstanding == 4'd0 && wr_outstanding == 4'd0;
        end
    end
endmodule

// File: tb/tb_axi_channel_slice.sv
module tb_axi_channel_slice;
    localparam int AX_W = 49;
    localparam int W_W  = 73;
    localparam int B_W  = 6;
    localparam int R_W  = 71;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // dut_s: registered/skid channels; dut_b: every channel bypassed.
    axi_channel_slice_if #(.W(AX_W)) s_in_aw (), s_out_aw (), s_in_ar (), s_out_ar ();
    axi_channel_slice_if #(.W(W_W))  s_in_w  (), s_out_w  ();
    axi_channel_slice_if #(.W(B_W))  s_in_b  (), s_out_b  ();
    axi_channel_slice_if #(.W(R_W))  s_in_r  (), s_out_r  ();
    axi_channel_slice_if #(.W(AX_W)) b_in_aw (), b_out_aw (), b_in_ar (), b_out_ar ();
    axi_channel_slice_if #(.W(W_W))  b_in_w  (), b_out_w  ();
    axi_channel_slice_if #(.W(B_W))  b_in_b  (), b_out_b  ();
    axi_channel_slice_if #(.W(R_W))  b_in_r  (), b_out_r  ();

    logic [3:0] s_rd, s_wr, b_rd, b_wr;
    logic       s_idle, b_idle;

    axi_channel_slice #(
        .MODE_AW(1), .MODE_W(2), .MODE_B(1), .MODE_AR(2), .MODE_R(1),
        .MAX_RD(15), .MAX_WR(4)
    ) dut_s (
        .clock(clock), .reset(reset),
        .in_aw(s_in_aw), .out_aw(s_out_aw), .in_w(s_in_w), .out_w(s_out_w),
        .in_b(s_in_b), .out_b(s_out_b), .in_ar(s_in_ar), .out_ar(s_out_ar),
        .in_r(s_in_r), .out_r(s_out_r),
        .rd_outstanding(s_rd), .wr_outstanding(s_wr), .idle(s_idle)
    );

    axi_channel_slice #(
        .MODE_AW(0), .MODE_W(0), .MODE_B(0), .MODE_AR(0), .MODE_R(0),
        .MAX_RD(2), .MAX_WR(2)
    ) dut_b (
        .clock(clock), .reset(reset),
        .in_aw(b_in_aw), .out_aw(b_out_aw), .in_w(b_in_w), .out_w(b_out_w),
        .in_b(b_in_b), .out_b(b_out_b), .in_ar(b_in_ar), .out_ar(b_out_ar),
        .in_r(b_in_r), .out_r(b_out_r),
        .rd_outstanding(b_rd), .wr_outstanding(b_wr), .idle(b_idle)
    );

    typedef struct {
        logic        ar_v;
        logic [31:0] ar_addr;
        logic        ar_rdy_out;
        logic        r_v;
        logic        r_last;
        logic        w_v;
        logic [63:0] w_data;
        logic        w_rdy_out;
        logic        exp_ar_v;
        logic        exp_ar_rdy;
        logic [3:0]  exp_rd;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [AX_W-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                              input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        return {id, addr, len, size, burst};
    endfunction

    function automatic logic [W_W-1:0] mk_w(input logic [63:0] data, input logic [7:0] strb,
                                            input logic last);
        return {data, strb, last};
    endfunction

    function automatic logic [B_W-1:0] mk_b(input logic [3:0] id, input logic [1:0] resp);
        return {id, resp};
    endfunction

    function automatic logic [R_W-1:0] mk_r(input logic [3:0] id, input logic [63:0] data,
                                            input logic [1:0] resp, input logic last);
        return {id, data, resp, last};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        {s_in_aw.valid, s_in_w.valid, s_in_b.valid, s_in_ar.valid, s_in_r.valid} = '0;
        {s_out_aw.ready, s_out_w.ready, s_out_b.ready, s_out_ar.ready, s_out_r.ready} = '0;
        {b_in_aw.valid, b_in_w.valid, b_in_b.valid, b_in_ar.valid, b_in_r.valid} = '0;
        {b_out_aw.ready, b_out_w.ready, b_out_b.ready, b_out_ar.ready} = '0;
        b_out_r.ready = 1'b1;
        b_out_ar.ready = 1'b1;
        s_in_aw.bits = '0; s_in_w.bits = '0; s_in_b.bits = '0; s_in_ar.bits = '0; s_in_r.bits = '0;
        b_in_aw.bits = '0; b_in_w.bits = '0; b_in_b.bits = '0; b_in_ar.bits = '0; b_in_r.bits = '0;

        //            ar_v addr        rdyo r_v last w_v data     w_rdy ex_v ex_rdy ex_rd
        vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 64'hAAAA, 1'b1, 1'b1, 1'b1, 4'd1};
        vecs[1]  = '{1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 4'd2};
        vecs[2]  = '{1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 4'd2};
        vecs[3]  = '{1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 4'd1};
        vecs[4]  = '{1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 4'd2};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 64'h55,   1'b1, 1'b0, 1'b0, 4'd2};
        vecs[6]  = '{1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 4'd1};
        vecs[8]  = '{1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 4'd1};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 4'd0};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 4'd0};

        // ---- reset state
        step();
        step();
        check("rst_s_in_w_ready", s_in_w.ready, 1'b0);
        check("rst_b_in_ar_ready", b_in_ar.ready, 1'b0);
        check("rst_s_out_w_valid", s_out_w.valid, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_idle", s_idle, 1'b1);
        check("post_rst_s_in_w_ready", s_in_w.ready, 1'b1);
        check("post_rst_s_in_aw_ready", s_in_aw.ready, 1'b1);
        check("post_rst_s_rd", s_rd, 4'd0);
        check("post_rst_b_in_ar_ready", b_in_ar.ready, 1'b1);
        b_out_ar.ready = 1'b0;

        // ---- write burst len=3, then B {5,0}
        s_out_aw.ready = 1'b1;
        s_in_aw.valid = 1'b1;
        s_in_aw.bits = mk_ax(4'd5, 32'h1000, 8'd3, 3'd3, 2'd1);
        #1;
        check("aw_in_ready", s_in_aw.ready, 1'b1);
        step();
        s_in_aw.valid = 1'b0;
        check("wr_after_aw", s_wr, 4'd1);
        check("aw_out_valid", s_out_aw.valid, 1'b1);
        check("aw_out_bits", s_out_aw.bits, mk_ax(4'd5, 32'h1000, 8'd3, 3'd3, 2'd1));
        step();
        check("aw_out_drained", s_out_aw.valid, 1'b0);
        s_out_w.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_w.valid = 1'b1;
            s_in_w.bits = mk_w(64'hD0 + 64'(i), 8'hFF, i == 3);
            step();
            check("w_burst_beat", s_out_w.bits, mk_w(64'hD0 + 64'(i), 8'hFF, i == 3));
        end
        s_in_w.valid = 1'b0;
        step();
        check("w_burst_drained", s_out_w.valid, 1'b0);
        s_out_b.ready = 1'b1;
        s_in_b.valid = 1'b1;
        s_in_b.bits = mk_b(4'd5, 2'd0);
        step();
        s_in_b.valid = 1'b0;
        check("b_out_valid", s_out_b.valid, 1'b1);
        check("b_out_bits", s_out_b.bits, {4'd5, 2'd0});
        check("wr_before_b", s_wr, 4'd1);
        step();
        check("wr_after_b", s_wr, 4'd0);
        check("idle_at_b", s_idle, 1'b0);
        step();
        check("idle_after_b", s_idle, 1'b1);

        // ---- AR skid stream: 8 back-to-back beats
        s_out_ar.ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            s_in_ar.valid = 1'b1;
            s_in_ar.bits = mk_ax(4'(n), 32'h8000_0000 + 32'(8 * n), 8'd0, 3'd3, 2'd1);
            #1;
            if (n == 0) check("ar_no_early_valid", s_out_ar.valid, 1'b0);
            check("ar_in_ready", s_in_ar.ready, 1'b1);
            step();
            check("ar_out_valid", s_out_ar.valid, 1'b1);
            check("ar_out_bits", s_out_ar.bits,
                  mk_ax(4'(n), 32'h8000_0000 + 32'(8 * n), 8'd0, 3'd3, 2'd1));
        end
        s_in_ar.valid = 1'b0;
        step();
        check("ar_stream_drained", s_out_ar.valid, 1'b0);
        check("rd_after_stream", s_rd, 4'd8);

        // ---- five R last beats bring rd_outstanding to 3
        s_out_r.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_in_r.valid = 1'b1;
            s_in_r.bits = mk_r(4'(k), 64'hE0 + 64'(k), 2'd0, 1'b1);
            step();
            if (k == 0) check("r_out_bits", s_out_r.bits, mk_r(4'd0, 64'hE0, 2'd0, 1'b1));
        end
        s_in_r.valid = 1'b0;
        step();
        check("rd_after_r", s_rd, 4'd3);

        // ---- W skid stall: 0x11, 0x22 accepted, 0x33 held off
        s_out_w.ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            s_in_w.valid = 1'b1;
            s_in_w.bits = mk_w(64'(8'h11 * i), 8'hFF, 1'b0);
            #1;
            check("w_stall_ready", s_in_w.ready, 1'b1);
            step();
        end
        s_in_w.bits = mk_w(64'h33, 8'hFF, 1'b1);
        #1;
        check("w_full_ready", s_in_w.ready, 1'b0);
        step();
        check("w_full_ready_hold", s_in_w.ready, 1'b0);
        check("w_head_11", s_out_w.bits, mk_w(64'h11, 8'hFF, 1'b0));
        s_out_w.ready = 1'b1;
        step();
        check("w_head_22", s_out_w.bits, mk_w(64'h22, 8'hFF, 1'b0));
        check("w_ready_again", s_in_w.ready, 1'b1);
        step();
        s_in_w.valid = 1'b0;
        check("w_head_33", s_out_w.bits, mk_w(64'h33, 8'hFF, 1'b1));
        check("w_head_33_valid", s_out_w.valid, 1'b1);
        step();
        check("w_no_dup", s_out_w.valid, 1'b0);

        // ---- reset with 2 W beats buffered and rd_outstanding = 3
        s_out_w.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_in_w.valid = 1'b1;
            s_in_w.bits = mk_w(64'hA1 + 64'(i), 8'hFF, 1'b0);
            step();
        end
        s_in_w.valid = 1'b0;
        check("pre_rst_rd", s_rd, 4'd3);
        check("pre_rst_w_valid", s_out_w.valid, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_w_valid_gated", s_out_w.valid, 1'b0);
        step();
        reset = 1'b0;
        check("rst_w_flushed", s_out_w.valid, 1'b0);
        check("rst_rd_cleared", s_rd, 4'd0);
        check("rst_idle", s_idle, 1'b1);
        s_out_w.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_stale_w", s_out_w.valid, 1'b0);
        end

        // ---- bypass table (MAX_RD = 2)
        for (int i = 0; i < 11; i++) begin
            b_in_ar.valid  = vecs[i].ar_v;
            b_in_ar.bits   = mk_ax(4'd1, vecs[i].ar_addr, 8'd0, 3'd3, 2'd1);
            b_out_ar.ready = vecs[i].ar_rdy_out;
            b_in_r.valid   = vecs[i].r_v;
            b_in_r.bits    = mk_r(4'd2, 64'hF0 + 64'(i), 2'd0, vecs[i].r_last);
            b_in_w.valid   = vecs[i].w_v;
            b_in_w.bits    = mk_w(vecs[i].w_data, 8'hFF, 1'b1);
            b_out_w.ready  = vecs[i].w_rdy_out;
            #1;
            check("byp_out_ar_valid", b_out_ar.valid, vecs[i].exp_ar_v);
            check("byp_in_ar_ready", b_in_ar.ready, vecs[i].exp_ar_rdy);
            check("byp_out_ar_bits", b_out_ar.bits, mk_ax(4'd1, vecs[i].ar_addr, 8'd0, 3'd3, 2'd1));
            check("byp_out_w_valid", b_out_w.valid, vecs[i].w_v);
            check("byp_in_w_ready", b_in_w.ready, vecs[i].w_rdy_out);
            check("byp_out_w_bits", b_out_w.bits, mk_w(vecs[i].w_data, 8'hFF, 1'b1));
            check("byp_out_r_valid", b_out_r.valid, vecs[i].r_v);
            check("byp_out_r_bits", b_out_r.bits, mk_r(4'd2, 64'hF0 + 64'(i), 2'd0, vecs[i].r_last));
            step();
            check("byp_rd", b_rd, vecs[i].exp_rd);
        end
        {b_in_ar.valid, b_in_r.valid, b_in_w.valid} = '0;

        // ---- bypass write limiter (MAX_WR = 2) and B pass-through
        b_out_aw.ready = 1'b1;
        b_in_aw.valid = 1'b1;
        b_in_aw.bits = mk_ax(4'd7, 32'h40, 8'd0, 3'd3, 2'd1);
        step();
        step();
        check("byp_wr_full", b_wr, 4'd2);
        check("byp_aw_ready_capped", b_in_aw.ready, 1'b0);
        check("byp_aw_valid_capped", b_out_aw.valid, 1'b0);
        b_in_aw.valid = 1'b0;
        b_out_b.ready = 1'b1;
        b_in_b.valid = 1'b1;
        b_in_b.bits = mk_b(4'd5, 2'd1);
        #1;
        check("byp_b_valid", b_out_b.valid, 1'b1);
        check("byp_b_bits", b_out_b.bits, {4'd5, 2'd1});
        step();
        check("byp_wr_dec", b_wr, 4'd1);
        step();
        b_in_b.valid = 1'b0;
        check("byp_wr_zero", b_wr, 4'd0);
        step();
        check("byp_idle", b_idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_channel_slice.md
Name: axi_channel_slice

Overview:
- Parametrised AXI4 register slice between the core AXI master port and the top-level MAXI_* pins.
- Each of the five channels (AW, W, B, AR, R) is independently configured as bypass, forward register or two-entry skid buffer.
- Limits outstanding read and write bursts and reports an idle/drained status for flush and reset sequencing.
- Payloads are packed buses; field order is MSB→LSB as listed under Ports.

Parameters:
- ID_W, 4, AXI id width
- ADDR_W, 32, address width
- DATA_W, 64, data width; power of two, at least 8
- MODE_AW / MODE_W / MODE_B / MODE_AR / MODE_R, 2 each, per-channel mode: 0 = bypass, 1 = forward register, 2 = full skid
- MAX_RD, 4, maximum outstanding read bursts (1..15)
- MAX_WR, 4, maximum outstanding write bursts (1..15)

Derived widths:
- AW_W = AR_W = ID_W+ADDR_W+13
- W_W = DATA_W+DATA_W/8+1
- B_W = ID_W+2
- R_W = ID_W+DATA_W+3

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_aw_valid / in_aw_ready / in_aw_bits  in/out/in  1/1/AW_W  from core; bits = {id, addr, len, size, burst}
- out_aw_valid / out_aw_ready / out_aw_bits  out/in/out  1/1/AW_W  to memory
- in_w_valid / in_w_ready / in_w_bits  in/out/in  1/1/W_W  from core; bits = {data, strb, last}
- out_w_valid / out_w_ready / out_w_bits  out/in/out  1/1/W_W  to memory
- in_b_valid / in_b_ready / in_b_bits  in/out/in  1/1/B_W  from memory; bits = {id, resp}
- out_b_valid / out_b_ready / out_b_bits  out/in/out  1/1/B_W  to core
- in_ar_valid / in_ar_ready / in_ar_bits  in/out/in  1/1/AR_W  from core; bits as AW
- out_ar_valid / out_ar_ready / out_ar_bits  out/in/out  1/1/AR_W  to memory
- in_r_valid / in_r_ready / in_r_bits  in/out/in  1/1/R_W  from memory; bits = {id, data, resp, last}
- out_r_valid / out_r_ready / out_r_bits  out/in/out  1/1/R_W  to core
- rd_outstanding  out  4  current outstanding read bursts
- wr_outstanding  out  4  current outstanding write bursts
- idle  out  1  all slices empty and both outstanding counters zero

Behaviour:
- Handshake: transfer occurs when valid && ready on the rising edge. A valid output never drops, and its bits never change, until it has been accepted.
- Mode 0 (bypass): out = in combinationally; ready passes straight through; no latency.
- Mode 1 (forward register):
  - out_valid and out_bits are registered; in_ready = !full || out_ready (combinational path through ready only).
  - Latency 1 cycle; full throughput.
- Mode 2 (full skid):
  - Two-entry buffer; in_ready and out_valid are both registered; no combinational in→out path.
  - Latency 1 cycle; throughput 1/cycle once primed.
  - in_ready = (count < 2), registered.
  - Push and pop in the same cycle at count 1: count stays 1, head advances, order is preserved.
  - Push while count = 2 cannot occur because in_ready is 0.
- Read limiter (in_ar side):
  - rd_outstanding increments on an in_ar handshake and decrements on an out_r handshake with last = 1.
  - Increment and decrement in the same cycle: value unchanged.
  - When rd_outstanding == MAX_RD: in_ar_ready is forced 0 and no AR enters the slice.
- Write limiter (in_aw side):
  - Same rules on in_aw handshake / out_b handshake, capped by MAX_WR.
  - The W channel is not gated.
- idle: registered; it is 1 in the cycle after all slice entries are empty and both counters are 0.
- A decrement at 0 (stray response) is a protocol error: the counter saturates at 0 and does not wrap.
- Reset:
  - All slice entries are invalidated and out_*_valid = 0; counters = 0.
  - While reset is high, all in_*_ready = 0. From the first cycle after reset falls, idle = 1 and the mode 1/2 in_*_ready = 1.
  - Reset asserted mid-burst discards buffered beats; no handshake completes in the reset cycle.

Test Plan:
- MODE_AR=2, out_ar_ready held 1, AR issued every cycle with addr 0x8000_0000 + 8·n:
  - out_ar_valid rises 1 cycle after the first in_ar_valid.
  - 8 consecutive beats appear back-to-back, in order, with bits unchanged.
- MODE_W=2, out_w_ready held 0 while 3 beats (data 0x11, 0x22, 0x33) are offered:
  - 2 beats are accepted, then in_w_ready = 0.
  - After out_w_ready rises: 0x11, 0x22, then 0x33 emerge, with no loss or duplication.
- MAX_RD=2, three ARs issued with R withheld:
  - rd_outstanding = 2 and in_ar_ready = 0 on the third AR.
  - After an R beat with last = 1 completes, the third AR is accepted and rd_outstanding returns to 2.
- A write burst of len = 3 (4 W beats) completes, then a B response with id 5, resp 0:
  - wr_outstanding goes 1 → 0.
  - out_b_bits = {5, 0}.
  - idle = 1 one cycle after the B handshake.
- Every channel set to MODE 0:
  - All out_* equal in_* in the same cycle; the limiters still count.
- Reset asserted with 2 W beats buffered and rd_outstanding = 3:
  - Next cycle: out_w_valid = 0, rd_outstanding = 0, idle = 1.
  - No buffered beat is ever emitted afterwards.
